// File: rtl/alu_mac_sequencer_pkg.sv
// Shared ALU opcode/word definitions and the MAC sequencer state encoding.
package alu_mac_sequencer_pkg;

  localparam int REG_WORD_LEN     = 16;
  localparam int ALU_MODE_LEN     = 4;
  localparam int SHIFT_LEN        = 4;
  localparam int MACSEQ_STATE_LEN = 2;

  localparam logic [ALU_MODE_LEN-1:0] ALU_NOP = 4'd0;
  localparam logic [ALU_MODE_LEN-1:0] ALU_MAC = 4'd6;

  typedef enum logic [MACSEQ_STATE_LEN-1:0] {
    MACSEQ_IDLE  = 2'd0,
    MACSEQ_RUN   = 2'd1,
    MACSEQ_DRAIN = 2'd2,
    MACSEQ_DONE  = 2'd3
  } macseq_state_e;

endpackage

// File: rtl/alu_mac_sequencer.sv
// Sequences the shared ALU through an N-tap MAC loop over sample/coefficient memories.
// Latency: done rises N+1 cycles after the start-sampling edge (one pair per cycle, no bubbles).
// Backpressure: none; start is only taken in idle, abort cancels without a done pulse.
module alu_mac_sequencer
  import alu_mac_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_W-1:0]        len,
  input  logic [ADDR_W-1:0]       x_base,
  input  logic [ADDR_W-1:0]       h_base,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       x_addr,
  output logic [ADDR_W-1:0]       h_addr,
  input  logic [REG_WORD_LEN-1:0] x_data,
  input  logic [REG_WORD_LEN-1:0] h_data,
  output logic [ALU_MODE_LEN-1:0] alu_opcode,
  output logic [REG_WORD_LEN-1:0] alu_a,
  output logic [REG_WORD_LEN-1:0] alu_b,
  output logic [REG_WORD_LEN-1:0] alu_c,
  output logic [SHIFT_LEN-1:0]    alu_shift,
  input  logic [REG_WORD_LEN-1:0] alu_out,
  output logic                    busy,
  output logic                    done,
  output logic [REG_WORD_LEN-1:0] result
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  macseq_state_e           state;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        idx;
  logic [REG_WORD_LEN-1:0] acc;
  logic                    rd_vld;

  // The ALU mux is only claimed while a returned pair is on x_data/h_data.
  assign alu_opcode = rd_vld ? ALU_MAC : ALU_NOP;
  assign alu_a      = rd_vld ? x_data  : '0;
  assign alu_b      = rd_vld ? h_data  : '0;
  assign alu_c      = rd_vld ? acc     : '0;
  assign alu_shift  = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= MACSEQ_IDLE;
      len_q     <= '0;
      idx       <= '0;
      acc       <= '0;
      rd_vld    <= 1'b0;
      mem_rd_en <= 1'b0;
      x_addr    <= '0;
      h_addr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      rd_vld <= mem_rd_en;
      if (rd_vld && !abort) acc <= alu_out;

      unique case (state)
        MACSEQ_IDLE: begin
          if (start && !abort) begin
            len_q  <= len;
            idx    <= '0;
            acc    <= '0;
            x_addr <= x_base;
            h_addr <= h_base;
            busy   <= 1'b1;
            // Zero-length runs pass straight through DRAIN so done keeps the N+1 latency.
            if (len != '0) begin
              state     <= MACSEQ_RUN;
              mem_rd_en <= 1'b1;
            end else begin
              state <= MACSEQ_DRAIN;
            end
          end
        end

        MACSEQ_RUN: begin
          if (abort) begin
            state     <= MACSEQ_IDLE;
            busy      <= 1'b0;
            mem_rd_en <= 1'b0;
            rd_vld    <= 1'b0;
          end else if (idx == len_q - LEN_ONE) begin
            state     <= MACSEQ_DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            idx    <= idx + LEN_ONE;
            x_addr <= x_addr + ADDR_ONE;
            h_addr <= h_addr + ADDR_ONE;
          end
        end

        MACSEQ_DRAIN: begin
          if (abort) begin
            state  <= MACSEQ_IDLE;
            busy   <= 1'b0;
            rd_vld <= 1'b0;
          end else begin
            state  <= MACSEQ_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= rd_vld ? alu_out : acc;
          end
        end

        MACSEQ_DONE: begin
          done  <= 1'b0;
          state <= MACSEQ_IDLE;
        end

        default: state <= MACSEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mac_sequencer.sv
// Directed bench: memory + sign-magnitude Q1.15 ALU model around the MAC sequencer.
module tb_alu_mac_sequencer;
  import alu_mac_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  len;
  logic [7:0]  x_base;
  logic [7:0]  h_base;
  logic        mem_rd_en;
  logic [7:0]  x_addr;
  logic [7:0]  h_addr;
  logic [15:0] x_data;
  logic [15:0] h_data;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_c;
  logic [3:0]  alu_shift;
  logic [15:0] alu_out;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int rd_cnt;
  int busy0;
  logic [7:0] xa_q[$];

  logic [15:0] xmem [256];
  logic [15:0] hmem [256];

  alu_mac_sequencer #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .x_base(x_base), .h_base(h_base), .mem_rd_en(mem_rd_en),
    .x_addr(x_addr), .h_addr(h_addr), .x_data(x_data), .h_data(h_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_shift(alu_shift), .alu_out(alu_out), .busy(busy), .done(done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories; junk on the bus when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      x_data <= xmem[x_addr];
      h_data <= hmem[h_addr];
    end else begin
      x_data <= 16'h5A5A;
      h_data <= 16'h5A5A;
    end
  end

  function automatic logic [15:0] qmult(input logic [15:0] a, input logic [15:0] b);
    logic [29:0] p;
    logic [14:0] mag;
    p   = a[14:0] * b[14:0];
    mag = p[29:15];
    return {(mag != 15'd0) && (a[15] ^ b[15]), mag};
  endfunction

  function automatic logic [15:0] qadd(input logic [15:0] a, input logic [15:0] b);
    logic [14:0] mag;
    logic        sgn;
    if (a[15] == b[15]) begin
      mag = a[14:0] + b[14:0];
      sgn = a[15];
    end else if (a[14:0] >= b[14:0]) begin
      mag = a[14:0] - b[14:0];
      sgn = a[15];
    end else begin
      mag = b[14:0] - a[14:0];
      sgn = b[15];
    end
    return {sgn && (mag != 15'd0), mag};
  endfunction

  always_comb begin
    alu_out = 16'h0000;
    if (alu_opcode == ALU_MAC) alu_out = qadd(qmult(alu_a, alu_b), alu_c);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start and wait (bounded) for done; records latency, reads and x addresses.
  task automatic do_run(input logic [7:0] n, input logic [7:0] xb, input logic [7:0] hb);
    len    = n;
    x_base = xb;
    h_base = hb;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    busy0  = int'(busy);
    rd_cnt = 0;
    lat    = 0;
    xa_q.delete();
    while (!done && lat < 400) begin
      if (mem_rd_en) begin
        rd_cnt++;
        xa_q.push_back(x_addr);
      end
      tick();
      lat++;
    end
  endtask

  task automatic watch_quiet(input int n, input string tag);
    int d = 0;
    int b = 0;
    repeat (n) begin
      tick();
      if (done) d++;
      if (busy) b++;
    end
    check({tag, "_done"}, d, 0);
    check({tag, "_busy"}, b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    len = 8'd0; x_base = 8'd0; h_base = 8'd0;
    for (int i = 0; i < 256; i++) begin
      xmem[i] = 16'h0100;
      hmem[i] = 16'h0100;
    end

    repeat (3) tick();
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_rd_en",  mem_rd_en, 0);
    check("rst_result", result, 16'h0000);
    check("rst_x_addr", x_addr, 8'h00);
    check("rst_h_addr", h_addr, 8'h00);
    check("rst_opcode", alu_opcode, ALU_NOP);
    check("rst_alu_a",  alu_a, 16'h0000);
    check("rst_shift",  alu_shift, 4'h0);
    rst_n = 1'b1;
    tick();

    // Max tap count: 255 products of 2 LSB each.
    do_run(8'd255, 8'h00, 8'h00);
    check("n255_lat",    lat, 256);
    check("n255_reads",  rd_cnt, 255);
    check("n255_result", result, 16'h01FE);
    tick();

    do_run(8'd0, 8'h00, 8'h00);
    check("n0_lat",    lat, 1);
    check("n0_reads",  rd_cnt, 0);
    check("n0_result", result, 16'h0000);
    tick();
    check("n0_done_pulse", done, 0);

    for (int i = 0; i < 4; i++) begin
      xmem[8'h10 + i] = 16'h4000;
      hmem[8'h20 + i] = 16'h2000;
    end
    do_run(8'd4, 8'h10, 8'h20);
    check("n4_busy",   busy0, 1);
    check("n4_lat",    lat, 5);
    check("n4_reads",  rd_cnt, 4);
    check("n4_result", result, 16'h4000);
    check("n4_busy_at_done", busy, 0);
    tick();
    check("n4_done_pulse", done, 0);
    check("n4_held", result, 16'h4000);

    xmem[8'h30] = 16'h4000; xmem[8'h31] = 16'h4000;
    hmem[8'h40] = 16'h4000; hmem[8'h41] = 16'hC000;
    do_run(8'd2, 8'h30, 8'h40);
    check("neg_lat",    lat, 3);
    check("neg_result", result, 16'h0000);
    tick();

    xmem[8'hFE] = 16'h4000; xmem[8'hFF] = 16'hA000;
    xmem[8'h00] = 16'h6000; xmem[8'h01] = 16'h1000;
    for (int i = 0; i < 4; i++) hmem[8'h7E + i] = 16'h4000;
    do_run(8'd4, 8'hFE, 8'h7E);
    check("wrap_reads",  rd_cnt, 4);
    check("wrap_qlen",   xa_q.size(), 4);
    if (xa_q.size() == 4) begin
      check("wrap_a0", xa_q[0], 8'hFE);
      check("wrap_a1", xa_q[1], 8'hFF);
      check("wrap_a2", xa_q[2], 8'h00);
      check("wrap_a3", xa_q[3], 8'h01);
    end
    check("wrap_result", result, 16'h4800);
    tick();

    // Reset in the middle of an 8-tap run, at idx 3.
    len = 8'd8; x_base = 8'h10; h_base = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mr_idx3_addr", x_addr, 8'h13);
    rst_n = 1'b0;
    tick();
    check("mr_busy",   busy, 0);
    check("mr_done",   done, 0);
    check("mr_rd_en",  mem_rd_en, 0);
    check("mr_result", result, 16'h0000);
    check("mr_x_addr", x_addr, 8'h00);
    check("mr_opcode", alu_opcode, ALU_NOP);
    rst_n = 1'b1;
    watch_quiet(12, "mr_after");

    do_run(8'd4, 8'h10, 8'h20);
    check("rerun_result", result, 16'h4000);
    tick();

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy",  busy, 0);
    check("sa_rd_en", mem_rd_en, 0);
    watch_quiet(4, "sa_after");

    // Abort while reads are in flight in RUN.
    len = 8'd4; x_base = 8'h10; h_base = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ar_busy",   busy, 0);
    check("ar_rd_en",  mem_rd_en, 0);
    check("ar_opcode", alu_opcode, ALU_NOP);
    check("ar_result", result, 16'h4000);
    watch_quiet(8, "ar_after");

    // Second start mid-run is dropped; abort lands in DRAIN.
    len = 8'd8; x_base = 8'h10; h_base = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("ad_drain_rd_en", mem_rd_en, 0);
    check("ad_drain_busy",  busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ad_busy",   busy, 0);
    check("ad_done",   done, 0);
    check("ad_result", result, 16'h4000);
    watch_quiet(10, "ad_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
